adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered 32-bit adder (`adder_32bit`) between NREQ requesters. It accepts level requests with operands, selects one requester fairly, and drives the adder operands. It waits out the adder latency, then returns the sum to the granted requester with a one-cycle valid pulse. It sits between client blocks and the single adder instance, and owns the adder's operand inputs.

---
 rtl/adder_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_adder_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter
// Description : Round-robin arbiter and sequencer in front of one shared,
//               registered adder. It grants one of NREQ level requesters,
//               drives that requester's operands to the adder, waits out the
//               adder latency and returns the sum with a one-cycle strobe.
//
// Ports
//   clk        rising-edge system clock
//   reset      asynchronous, active-low reset
//   req        level request per requester (held until its gnt bit is seen)
//   a_in/b_in  packed operands, slice i = x_in[i*WIDTH +: WIDTH]
//   add_a/b    registered operands presented to the shared adder
//   add_sum    result returned by the shared adder
//   gnt        one-hot grant pulse; operands of that requester were captured
//   rsp_valid  one-hot response strobe back to the granted requester
//   rsp_sum    captured result, held until the next response
//   busy       high while an operation is in flight
//
// Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int ADD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_sum,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  busy
);

  localparam int               PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One extra bit so ptr + offset (< 2*NREQ) never overflows before the wrap.
  localparam int               SUM_W    = PTR_W + 1;
  localparam logic [2:0]       CNT_INIT = 3'(ADD_LAT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);
  localparam logic [NREQ-1:0]  ONE_BIT  = NREQ'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t             state_q,     state_d;
  logic [PTR_W-1:0]   ptr_q,       ptr_d;
  logic [NREQ-1:0]    owner_q,     owner_d;
  logic [2:0]         cnt_q,       cnt_d;
  logic [WIDTH-1:0]   add_a_q,     add_a_d;
  logic [WIDTH-1:0]   add_b_q,     add_b_d;
  logic [NREQ-1:0]    gnt_q,       gnt_d;
  logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_sum_q,   rsp_sum_d;

  // --------------------------------------------------------------------------
  // Operand unpacking
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] a_slice [NREQ];
  logic [WIDTH-1:0] b_slice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_slice[i] = a_in[i*WIDTH +: WIDTH];
    assign b_slice[i] = b_in[i*WIDTH +: WIDTH];
  end

  // --------------------------------------------------------------------------
  // Round-robin winner search: first set req bit at ptr, ptr+1, ... mod NREQ.
  // The wrap is done by a single conditional subtract so that non-power-of-2
  // NREQ values wrap correctly.
  // --------------------------------------------------------------------------
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [SUM_W-1:0] scan_sum;
  logic [PTR_W-1:0] scan_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr_q} + SUM_W'(k);
      if (scan_sum >= SUM_W'(NREQ)) begin
        scan_sum = scan_sum - SUM_W'(NREQ);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    gnt_d       = '0;          // strobes default low: one-cycle pulses
    rsp_valid_d = '0;
    rsp_sum_d   = rsp_sum_q;   // result is held between responses

    case (state_q)
      IDLE: begin
        if (win_found) begin
          add_a_d = a_slice[win_idx];
          add_b_d = b_slice[win_idx];
          gnt_d   = ONE_BIT << win_idx;
          owner_d = ONE_BIT << win_idx;
          ptr_d   = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end

      WAIT: begin
        // req is deliberately ignored here; the operands to the adder stay
        // frozen until the result has been captured.
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          rsp_sum_d   = add_sum;
          rsp_valid_d = owner_q;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign busy      = (state_q == WAIT);

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Scoreboard bench for adder_arbiter. A transaction-level model
//               predicts each grant and response; a monitor compares what
//               the DUT presents. A second instance uses a 3-cycle adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;
  localparam int N    = 4;
  localparam int W    = 32;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance (ADD_LAT = 1) ----------------
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in, b_in;
  logic [W-1:0]   add_a, add_b, add_sum, rsp_sum;
  logic [N-1:0]   gnt, rsp_valid;
  logic           busy;
  logic [W-1:0]   op_a [N];
  logic [W-1:0]   op_b [N];

  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = op_a[i];
      b_in[i*W +: W] = op_b[i];
    end
  end

  adder_arbiter #(.NREQ(N), .WIDTH(W), .ADD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .busy(busy)
  );

  logic [W-1:0] pipe1 [LAT];
  always @(posedge clk) begin
    pipe1[0] <= add_a + add_b;
    for (int k = 1; k < LAT; k++) pipe1[k] <= pipe1[k-1];
  end
  assign add_sum = pipe1[LAT-1];

  // ---------------- second instance (ADD_LAT = 3) ----------------
  logic [N-1:0]   req3;
  logic [N*W-1:0] a_in3, b_in3;
  logic [W-1:0]   add_a3, add_b3, add_sum3, rsp_sum3;
  logic [N-1:0]   gnt3, rsp_valid3;
  logic           busy3;

  adder_arbiter #(.NREQ(N), .WIDTH(W), .ADD_LAT(LAT3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .a_in(a_in3), .b_in(b_in3),
    .add_a(add_a3), .add_b(add_b3), .add_sum(add_sum3), .gnt(gnt3),
    .rsp_valid(rsp_valid3), .rsp_sum(rsp_sum3), .busy(busy3)
  );

  logic [W-1:0] pipe3 [LAT3];
  always @(posedge clk) begin
    pipe3[0] <= add_a3 + add_b3;
    for (int k = 1; k < LAT3; k++) pipe3[k] <= pipe3[k-1];
  end
  assign add_sum3 = pipe3[LAT3-1];

  // ---------------- scoreboard ----------------
  typedef struct { int idx; int cyc; logic [W-1:0] a; logic [W-1:0] b; } gexp_t;
  typedef struct { int idx; int cyc; logic [W-1:0] sum; } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t g;
  rexp_t r;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_ptr = 0;
  int m_free = 0;
  int m_busy_from = 0;
  logic [W-1:0] last_sum = '0;
  logic mon_en = 1'b0;

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Arbiter is free from m_free on; a grant serves the first requester at
  // or after the model pointer, and occupies LAT+2 cycles.
  task automatic model_arb();
    int w;
    int i;
    w = -1;
    if (cyc >= m_free && req != '0) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (w < 0 && req[i]) w = i;
      end
      gq.push_back('{w, cyc + 1, op_a[w], op_b[w]});
      rq.push_back('{w, cyc + LAT + 2, op_a[w] + op_b[w]});
      m_busy_from = cyc + 1;
      m_free      = cyc + LAT + 2;
      m_ptr       = (w + 1) % N;
    end
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i] = a;
    op_b[i] = b;
    req[i]  = 1'b1;
  endtask

  // Requesters drop on their grant; idle requesters in mask raise a new
  // request with probability p percent.
  task automatic drive_cycle(input int p, input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) req[i] = 1'b0;
      else if (!req[i] && mask[i] && ($urandom_range(99) < p)) issue(i, $urandom, $urandom);
    end
    model_arb();
  endtask

  task automatic run(input int n, input int p, input logic [N-1:0] mask);
    for (int c = 0; c < n; c++) begin
      step();
      drive_cycle(p, mask);
    end
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("rst_gnt", gnt, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_sum", rsp_sum, '0);
    chk("rst_add_a", add_a, '0);
    chk("rst_add_b", add_b, '0);
    chk("rst_busy", busy, '0);
    gq.delete();
    rq.delete();
    req = '0;
    m_ptr = 0;
    last_sum = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step();
    m_free = cyc;
    m_busy_from = cyc;
    mon_en = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL gnt_missing: got none expected requester %0d in cycle %0d", gq[0].idx, gq[0].cyc);
        void'(gq.pop_front());
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL rsp_missing: got none expected requester %0d in cycle %0d", rq[0].idx, rq[0].cyc);
        void'(rq.pop_front());
      end
      if (gnt != '0) begin
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL gnt_unexpected: got %b expected 0 (cycle %0d)", gnt, cyc);
        end else begin
          g = gq.pop_front();
          chk("gnt_vec", gnt, onehot(g.idx));
          chk("gnt_cycle", cyc, g.cyc);
          chk("add_a", add_a, g.a);
          chk("add_b", add_b, g.b);
        end
      end
      if (rsp_valid != '0) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got %b expected 0 (cycle %0d)", rsp_valid, cyc);
        end else begin
          r = rq.pop_front();
          chk("rsp_valid_vec", rsp_valid, onehot(r.idx));
          chk("rsp_cycle", cyc, r.cyc);
          chk("rsp_sum", rsp_sum, r.sum);
          last_sum = r.sum;
        end
      end else begin
        chk("rsp_sum_hold", rsp_sum, last_sum);
      end
      chk("busy", busy, (cyc >= m_busy_from && cyc < m_free) ? 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] exp3;

  initial begin
    req   = '0;
    req3  = '0;
    a_in3 = '0;
    b_in3 = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    apply_reset();

    // Single request: 1 + 2 on requester 1
    issue(1, 32'h0000_0001, 32'h0000_0002);
    model_arb();
    run(6, 0, '0);

    // Wrap-around: FFFFFFFF + 1 on requester 0
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001);
    model_arb();
    run(6, 0, '0);

    // All four at once from reset, distinct operands
    apply_reset();
    for (int i = 0; i < N; i++) issue(i, 32'h1000_0000 * (i + 1) + i, 32'h0000_0100 * (i + 3));
    model_arb();
    run(16, 0, '0);

    // Fairness: requesters 0 and 2 keep re-asserting
    run(40, 100, 4'b0101);
    run(6, 0, '0);

    // Random traffic
    run(300, 35, '1);
    run(8, 0, '0);

    // Reset in WAIT after a grant to requester 3
    issue(3, $urandom, $urandom);
    model_arb();
    run(2, 0, '0);
    apply_reset();
    run(8, 0, '0);
    issue(1, $urandom, $urandom);
    issue(3, $urandom, $urandom);
    model_arb();
    run(10, 0, '0);

    // ADD_LAT = 3 instance: 12345678 + 11111111
    a_in3[2*W +: W] = 32'h1234_5678;
    b_in3[2*W +: W] = 32'h1111_1111;
    exp3 = 32'h1234_5678 + 32'h1111_1111;
    req3 = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (gnt3[2]) req3 = '0;
      if (k == 1) chk("lat3_gnt", gnt3, 4'b0100);
      if (k == 5) begin
        chk("lat3_rsp_valid", rsp_valid3, 4'b0100);
        chk("lat3_rsp_sum", rsp_sum3, exp3);
      end else begin
        chk("lat3_no_rsp", rsp_valid3, '0);
      end
      chk("lat3_busy", busy3, (k <= 4) ? 1 : 0);
    end

    @(negedge clk);
    #1;
    chk("queue_drain", gq.size() + rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
